// File: rtl/alu_cmd_engine.sv
// Byte-stream packet engine: ECHO pass-through plus multi-operand ADD/MUL/AND/OR/XOR
// reductions over OPERAND_BYTES-wide little-endian operands, with valid/ready on both streams.
module alu_cmd_engine #(
    parameter int OPERAND_BYTES = 4,
    parameter int LEN_WIDTH     = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    output logic       rx_ready_o,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    output logic       busy_o
);

    localparam int W = 8 * OPERAND_BYTES;
    localparam logic [2:0] LAST_BYTE = 3'(OPERAND_BYTES - 1);

    localparam logic [7:0] OP_ECHO = 8'hEC;
    localparam logic [7:0] OP_ADD  = 8'hAD;
    localparam logic [7:0] OP_MUL  = 8'hA8;
    localparam logic [7:0] OP_AND  = 8'hA1;
    localparam logic [7:0] OP_OR   = 8'hA0;
    localparam logic [7:0] OP_XOR  = 8'hA9;

    typedef enum logic [3:0] {
        S_IDLE, S_RSVD, S_LEN_LO, S_LEN_HI, S_ECHO,
        S_OPERAND, S_COMPUTE, S_DRAIN, S_TX
    } state_t;

    state_t               state_q, state_d;
    logic [7:0]           op_q, op_d;
    logic [7:0]           len_lo_q, len_lo_d;
    logic [LEN_WIDTH-1:0] rem_q, rem_d;
    logic [2:0]           cnt_q, cnt_d;
    logic                 first_q, first_d;
    logic [W-1:0]         acc_q, acc_d;
    logic [W-1:0]         opnd_q, opnd_d;

    logic                 rx_ready_s;
    logic                 tx_valid_s;
    logic [7:0]           tx_data_s;
    logic [7:0]           tx_byte_s;
    logic                 rx_fire_s;
    logic                 tx_fire_s;
    logic [LEN_WIDTH-1:0] len_s;
    logic [LEN_WIDTH-1:0] pay_s;

    function automatic logic known_op(input logic [7:0] op);
        case (op)
            OP_ECHO, OP_ADD, OP_MUL, OP_AND, OP_OR, OP_XOR: known_op = 1'b1;
            default:                                       known_op = 1'b0;
        endcase
    endfunction

    function automatic logic [W-1:0] alu(input logic [7:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
        case (op)
            OP_ADD:  alu = a + b;
            OP_MUL:  alu = a * b;
            OP_AND:  alu = a & b;
            OP_OR:   alu = a | b;
            OP_XOR:  alu = a ^ b;
            default: alu = a;
        endcase
    endfunction

    // Result byte selected by the shared byte counter while transmitting.
    always_comb begin
        tx_byte_s = 8'h00;
        for (int b = 0; b < OPERAND_BYTES; b++) begin
            if (cnt_q == 3'(b)) begin
                tx_byte_s = acc_q[b*8 +: 8];
            end else begin
                tx_byte_s = tx_byte_s;
            end
        end
    end

    // Stream handshake decode; only ECHO passes rx straight through to tx.
    always_comb begin
        rx_ready_s = 1'b0;
        tx_valid_s = 1'b0;
        tx_data_s  = 8'h00;
        case (state_q)
            S_IDLE, S_RSVD, S_LEN_LO, S_LEN_HI, S_OPERAND, S_DRAIN: begin
                rx_ready_s = 1'b1;
            end
            S_ECHO: begin
                rx_ready_s = tx_ready_i;
                tx_valid_s = rx_valid_i;
                tx_data_s  = rx_data_i;
            end
            S_TX: begin
                tx_valid_s = 1'b1;
                tx_data_s  = tx_byte_s;
            end
            default: begin
                rx_ready_s = 1'b0;
            end
        endcase
    end

    assign rx_ready_o = rx_ready_s & rst_ni;
    assign tx_valid_o = tx_valid_s;
    assign tx_data_o  = tx_data_s;
    assign busy_o     = (state_q != S_IDLE);
    assign rx_fire_s  = rx_valid_i & rx_ready_s;
    assign tx_fire_s  = tx_valid_s & tx_ready_i;
    assign len_s      = {rx_data_i, len_lo_q};
    assign pay_s      = (len_s >= LEN_WIDTH'(4)) ? (len_s - LEN_WIDTH'(4)) : '0;

    // Packet sequencing, operand assembly and accumulation.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        len_lo_d = len_lo_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        first_d  = first_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        case (state_q)
            S_IDLE: begin
                if (rx_fire_s && known_op(rx_data_i)) begin
                    op_d    = rx_data_i;
                    state_d = S_RSVD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RSVD: begin
                if (rx_fire_s) state_d = S_LEN_LO;
                else           state_d = S_RSVD;
            end
            S_LEN_LO: begin
                if (rx_fire_s) begin
                    len_lo_d = rx_data_i;
                    state_d  = S_LEN_HI;
                end else begin
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_HI: begin
                if (rx_fire_s) begin
                    rem_d   = pay_s;
                    cnt_d   = 3'd0;
                    first_d = 1'b1;
                    acc_d   = '0;
                    if (op_q == OP_ECHO) begin
                        state_d = (pay_s == '0) ? S_IDLE : S_ECHO;
                    end else if (pay_s == '0) begin
                        state_d = S_TX;
                    end else if (pay_s < LEN_WIDTH'(OPERAND_BYTES)) begin
                        // Payload too short for even one operand: discard it, result stays 0.
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_OPERAND;
                    end
                end else begin
                    state_d = S_LEN_HI;
                end
            end
            S_ECHO: begin
                if (rem_q == '0) begin
                    state_d = S_IDLE;
                end else if (rx_fire_s) begin
                    rem_d   = rem_q - LEN_WIDTH'(1);
                    state_d = (rem_q == LEN_WIDTH'(1)) ? S_IDLE : S_ECHO;
                end else begin
                    state_d = S_ECHO;
                end
            end
            S_OPERAND: begin
                if (rx_fire_s) begin
                    for (int b = 0; b < OPERAND_BYTES; b++) begin
                        if (cnt_q == 3'(b)) opnd_d[b*8 +: 8] = rx_data_i;
                        else                opnd_d[b*8 +: 8] = opnd_q[b*8 +: 8];
                    end
                    rem_d = rem_q - LEN_WIDTH'(1);
                    if (cnt_q == LAST_BYTE) begin
                        cnt_d   = 3'd0;
                        state_d = S_COMPUTE;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end else begin
                    state_d = S_OPERAND;
                end
            end
            S_COMPUTE: begin
                acc_d   = first_q ? opnd_q : alu(op_q, acc_q, opnd_q);
                first_d = 1'b0;
                if (rem_q == '0)                                  state_d = S_TX;
                else if (rem_q < LEN_WIDTH'(OPERAND_BYTES))       state_d = S_DRAIN;
                else                                              state_d = S_OPERAND;
            end
            S_DRAIN: begin
                if (rem_q == '0) begin
                    state_d = S_TX;
                end else if (rx_fire_s) begin
                    rem_d   = rem_q - LEN_WIDTH'(1);
                    state_d = (rem_q == LEN_WIDTH'(1)) ? S_TX : S_DRAIN;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_TX: begin
                if (tx_fire_s) begin
                    if (cnt_q == LAST_BYTE) begin
                        cnt_d   = 3'd0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end else begin
                    state_d = S_TX;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            op_q     <= 8'h00;
            len_lo_q <= 8'h00;
            rem_q    <= '0;
            cnt_q    <= 3'd0;
            first_q  <= 1'b0;
            acc_q    <= '0;
            opnd_q   <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            len_lo_q <= len_lo_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            first_q  <= first_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
        end
    end

endmodule
